// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 16-bit single-port memory between the CPU
// instruction-fetch port and the CPU data port.
//
// One request is latched at a time and replayed on the memory port.
// Ties are broken round-robin. An access the memory never acknowledges is
// aborted after TIMEOUT bus cycles, and the requester gets an error response.
//
// Ports:
//   sys_clk, sys_rst            rising-edge clock, synchronous active-high reset
//   instr_* (stb/we/addr/data)  instruction-side request; data_o/ack_o/err_o response
//   data_*  (stb/we/addr/data)  data-side request; data_o/ack_o/err_o response
//   mem_stb_o/we_o/addr_o/data_o  memory request
//   mem_data_i/mem_ack_i        memory response
//   grant_o                     current owner: 00 none, 01 instr, 10 data
// All outputs are registered.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        instr_stb_i,
  input  logic        instr_we_i,
  input  logic [15:0] instr_addr_i,
  input  logic [15:0] instr_data_i,
  output logic [15:0] instr_data_o,
  output logic        instr_ack_o,
  output logic        instr_err_o,
  input  logic        data_stb_i,
  input  logic        data_we_i,
  input  logic [15:0] data_addr_i,
  input  logic [15:0] data_data_i,
  output logic [15:0] data_data_o,
  output logic        data_ack_o,
  output logic        data_err_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_data_o,
  input  logic [15:0] mem_data_i,
  input  logic        mem_ack_i,
  output logic [1:0]  grant_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] GNT_NONE  = 2'b00;
  localparam logic [1:0] GNT_INSTR = 2'b01;
  localparam logic [1:0] GNT_DATA  = 2'b10;

  // Counter value on the last bus cycle before an abort.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic            last_grant_q, last_grant_d;   // 0 instr, 1 data; also owner while busy
  logic [1:0]      grant_q, grant_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            mem_stb_q, mem_stb_d;
  logic            mem_we_q, mem_we_d;
  logic [15:0]     mem_addr_q, mem_addr_d;
  logic [15:0]     mem_wdata_q, mem_wdata_d;
  logic [15:0]     instr_rdata_q, instr_rdata_d;
  logic            instr_ack_q, instr_ack_d;
  logic            instr_err_q, instr_err_d;
  logic [15:0]     data_rdata_q, data_rdata_d;
  logic            data_ack_q, data_ack_d;
  logic            data_err_q, data_err_d;
  logic            win_c;                         // 1 when the data side wins in IDLE

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    mem_stb_d     = mem_stb_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    instr_rdata_d = instr_rdata_q;
    data_rdata_d  = data_rdata_q;
    instr_ack_d   = 1'b0;
    instr_err_d   = 1'b0;
    data_ack_d    = 1'b0;
    data_err_d    = 1'b0;
    win_c         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_stb_i || data_stb_i) begin
          // On a tie, the side that did not win last time goes next.
          win_c        = (instr_stb_i && data_stb_i) ? ~last_grant_q : data_stb_i;
          last_grant_d = win_c;
          grant_d      = win_c ? GNT_DATA : GNT_INSTR;
          mem_we_d     = win_c ? data_we_i   : instr_we_i;
          mem_addr_d   = win_c ? data_addr_i : instr_addr_i;
          mem_wdata_d  = win_c ? data_data_i : instr_data_i;
          mem_stb_d    = 1'b1;
          cnt_d        = '0;
          state_d      = ST_BUS;
        end
      end

      ST_BUS: begin
        cnt_d = cnt_q + TO_W'(1);
        // An ack on the expiry cycle still completes normally.
        if (mem_ack_i) begin
          mem_stb_d = 1'b0;
          state_d   = ST_RESP;
          if (last_grant_q) begin
            data_rdata_d = mem_data_i;
            data_ack_d   = 1'b1;
          end else begin
            instr_rdata_d = mem_data_i;
            instr_ack_d   = 1'b1;
          end
        end else if (cnt_q == TO_LAST) begin
          mem_stb_d = 1'b0;
          state_d   = ST_RESP;
          if (last_grant_q) begin
            data_rdata_d = 16'hFFFF;
            data_ack_d   = 1'b1;
            data_err_d   = 1'b1;
          end else begin
            instr_rdata_d = 16'hFFFF;
            instr_ack_d   = 1'b1;
            instr_err_d   = 1'b1;
          end
        end
      end

      ST_RESP: begin
        // The response pulse is on the outputs this cycle; requests are ignored.
        grant_d = GNT_NONE;
        state_d = ST_IDLE;
      end

      default: begin
        grant_d   = GNT_NONE;
        mem_stb_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= GNT_NONE;
      cnt_q         <= '0;
      mem_stb_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      instr_rdata_q <= '0;
      instr_ack_q   <= 1'b0;
      instr_err_q   <= 1'b0;
      data_rdata_q  <= '0;
      data_ack_q    <= 1'b0;
      data_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      cnt_q         <= cnt_d;
      mem_stb_q     <= mem_stb_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      instr_rdata_q <= instr_rdata_d;
      instr_ack_q   <= instr_ack_d;
      instr_err_q   <= instr_err_d;
      data_rdata_q  <= data_rdata_d;
      data_ack_q    <= data_ack_d;
      data_err_q    <= data_err_d;
    end
  end

  assign instr_data_o = instr_rdata_q;
  assign instr_ack_o  = instr_ack_q;
  assign instr_err_o  = instr_err_q;
  assign data_data_o  = data_rdata_q;
  assign data_ack_o   = data_ack_q;
  assign data_err_o   = data_err_q;
  assign mem_stb_o    = mem_stb_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_wdata_q;
  assign grant_o      = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Inputs are driven and outputs sampled
// on the falling clock edge; the DUT acts on the rising edge.
module tb_mem_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        instr_stb_i, instr_we_i;
  logic [15:0] instr_addr_i, instr_data_i, instr_data_o;
  logic        instr_ack_o, instr_err_o;
  logic        data_stb_i, data_we_i;
  logic [15:0] data_addr_i, data_data_i, data_data_o;
  logic        data_ack_o, data_err_o;
  logic        mem_stb_o, mem_we_o;
  logic [15:0] mem_addr_o, mem_data_o, mem_data_i;
  logic        mem_ack_i;
  logic [1:0]  grant_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 sys_clk = ~sys_clk;

  mem_arbiter #(.TIMEOUT(15), .TO_W(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .instr_stb_i(instr_stb_i), .instr_we_i(instr_we_i),
    .instr_addr_i(instr_addr_i), .instr_data_i(instr_data_i),
    .instr_data_o(instr_data_o), .instr_ack_o(instr_ack_o), .instr_err_o(instr_err_o),
    .data_stb_i(data_stb_i), .data_we_i(data_we_i),
    .data_addr_i(data_addr_i), .data_data_i(data_data_i),
    .data_data_o(data_data_o), .data_ack_o(data_ack_o), .data_err_o(data_err_o),
    .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .grant_o(grant_o)
  );

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    instr_stb_i = 0; instr_we_i = 0; instr_addr_i = 0; instr_data_i = 0;
    data_stb_i = 0; data_we_i = 0; data_addr_i = 0; data_data_i = 0;
    mem_data_i = 0; mem_ack_i = 0;
    tick(); tick();
    n_cmp++;
    if ({grant_o, mem_stb_o, mem_we_o, mem_addr_o, mem_data_o} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_mem: got grant=%b stb=%b we=%b addr=%h wd=%h expected all 0",
               grant_o, mem_stb_o, mem_we_o, mem_addr_o, mem_data_o);
    end
    n_cmp++;
    if ({instr_ack_o, instr_err_o, data_ack_o, data_err_o, instr_data_o, data_data_o} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_resp: got iack=%b ierr=%b dack=%b derr=%b id=%h dd=%h expected all 0",
               instr_ack_o, instr_err_o, data_ack_o, data_err_o, instr_data_o, data_data_o);
    end
    sys_rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    data_stb_i = 1; data_we_i = 0; data_addr_i = 16'h0040;
    tick();  // BUS
    n_cmp++;
    if ({mem_stb_o, mem_we_o, mem_addr_o, grant_o} !== {1'b1, 1'b0, 16'h0040, 2'b10}) begin
      n_fail++;
      $display("FAIL read_bus: got stb=%b we=%b addr=%h grant=%b expected 1 0 0040 10",
               mem_stb_o, mem_we_o, mem_addr_o, grant_o);
    end
    mem_ack_i = 1; mem_data_i = 16'hBEEF;
    tick();  // RESP
    n_cmp++;
    if ({mem_stb_o, data_ack_o, data_err_o, data_data_o, instr_ack_o, grant_o} !==
        {1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b0, 2'b10}) begin
      n_fail++;
      $display("FAIL read_resp: got stb=%b dack=%b derr=%b dd=%h iack=%b grant=%b expected 0 1 0 beef 0 10",
               mem_stb_o, data_ack_o, data_err_o, data_data_o, instr_ack_o, grant_o);
    end
    mem_ack_i = 0; data_stb_i = 0;
    tick();  // IDLE
    n_cmp++;
    if ({data_ack_o, grant_o, mem_stb_o} !== {1'b0, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL read_idle: got dack=%b grant=%b stb=%b expected 0 00 0", data_ack_o, grant_o, mem_stb_o);
    end
  endtask

  task automatic test_write_wait();
    instr_stb_i = 1; instr_we_i = 1; instr_addr_i = 16'h0010; instr_data_i = 16'h1234;
    tick();
    // Changed requester inputs must not reach the memory port.
    instr_addr_i = 16'h7777; instr_data_i = 16'h9999;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({mem_stb_o, mem_we_o, mem_addr_o, mem_data_o, grant_o} !==
          {1'b1, 1'b1, 16'h0010, 16'h1234, 2'b01}) begin
        n_fail++;
        $display("FAIL write_bus[%0d]: got stb=%b we=%b addr=%h wd=%h grant=%b expected 1 1 0010 1234 01",
                 i, mem_stb_o, mem_we_o, mem_addr_o, mem_data_o, grant_o);
      end
      if (i == 3) mem_ack_i = 1;
      tick();
    end
    n_cmp++;
    if ({instr_ack_o, instr_err_o, data_ack_o, data_data_o, mem_stb_o} !==
        {1'b1, 1'b0, 1'b0, 16'hBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL write_resp: got iack=%b ierr=%b dack=%b dd=%h stb=%b expected 1 0 0 beef 0",
               instr_ack_o, instr_err_o, data_ack_o, data_data_o, mem_stb_o);
    end
    mem_ack_i = 0; instr_stb_i = 0; instr_we_i = 0;
    tick();
    n_cmp++;
    if (instr_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL write_pulse: got iack=%b expected 0", instr_ack_o);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [12];
    logic       exp_i [12];
    logic       exp_d [12];
    exp_g = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    exp_i = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    exp_d = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    sys_rst = 1; tick(); sys_rst = 0;
    instr_stb_i = 1; instr_addr_i = 16'h0100;
    data_stb_i = 1; data_we_i = 0; data_addr_i = 16'h0200;
    mem_ack_i = 1; mem_data_i = 16'h5555;  // always-ready memory; ack outside BUS is ignored
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if ({grant_o, instr_ack_o, data_ack_o} !== {exp_g[i], exp_i[i], exp_d[i]}) begin
        n_fail++;
        $display("FAIL contend[%0d]: got grant=%b iack=%b dack=%b expected %b %b %b",
                 i, grant_o, instr_ack_o, data_ack_o, exp_g[i], exp_i[i], exp_d[i]);
      end
    end
    instr_stb_i = 0; data_stb_i = 0; mem_ack_i = 0;
    tick();
  endtask

  task automatic test_timeout();
    int stb_cycles = 0;
    bit got_ack = 0;
    data_stb_i = 1; data_we_i = 0; data_addr_i = 16'h0080; mem_ack_i = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (data_ack_o) begin got_ack = 1; break; end
      if (mem_stb_o) stb_cycles++;
    end
    n_cmp++;
    if ({got_ack, data_err_o, data_data_o, mem_stb_o} !== {1'b1, 1'b1, 16'hFFFF, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_resp: got ack=%b err=%b dd=%h stb=%b expected 1 1 ffff 0",
               got_ack, data_err_o, data_data_o, mem_stb_o);
    end
    n_cmp++;
    if (stb_cycles != 15) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d stb cycles expected 15", stb_cycles);
    end
    data_stb_i = 0;
    tick();
    n_cmp++;
    if ({data_ack_o, data_err_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_pulse: got ack=%b err=%b expected 0 0", data_ack_o, data_err_o);
    end
    // Next request is served normally.
    data_stb_i = 1; data_addr_i = 16'h0081;
    tick();
    mem_ack_i = 1; mem_data_i = 16'h1111;
    tick();
    n_cmp++;
    if ({data_ack_o, data_err_o, data_data_o} !== {1'b1, 1'b0, 16'h1111}) begin
      n_fail++;
      $display("FAIL timeout_next: got ack=%b err=%b dd=%h expected 1 0 1111",
               data_ack_o, data_err_o, data_data_o);
    end
    mem_ack_i = 0; data_stb_i = 0;
    tick();
  endtask

  task automatic test_ack_expiry();
    data_stb_i = 1; data_we_i = 0; data_addr_i = 16'h00C0; mem_ack_i = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 15) begin mem_ack_i = 1; mem_data_i = 16'h5A5A; end
    end
    n_cmp++;
    if (mem_stb_o !== 1'b1) begin
      n_fail++;
      $display("FAIL expiry_bus: got stb=%b expected 1 on 15th bus cycle", mem_stb_o);
    end
    tick();
    n_cmp++;
    if ({data_ack_o, data_err_o, data_data_o} !== {1'b1, 1'b0, 16'h5A5A}) begin
      n_fail++;
      $display("FAIL expiry_resp: got ack=%b err=%b dd=%h expected 1 0 5a5a",
               data_ack_o, data_err_o, data_data_o);
    end
    mem_ack_i = 0; data_stb_i = 0;
    tick();
  endtask

  task automatic test_reset_mid_bus();
    data_stb_i = 1; data_we_i = 0; data_addr_i = 16'h0300; mem_ack_i = 0;
    tick(); tick(); tick();
    n_cmp++;
    if ({mem_stb_o, grant_o} !== {1'b1, 2'b10}) begin
      n_fail++;
      $display("FAIL rstmid_pre: got stb=%b grant=%b expected 1 10", mem_stb_o, grant_o);
    end
    instr_stb_i = 1; instr_we_i = 0; instr_addr_i = 16'h0400;
    sys_rst = 1;
    tick();
    n_cmp++;
    if ({mem_stb_o, grant_o, data_ack_o, instr_ack_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL rstmid_drop: got stb=%b grant=%b dack=%b iack=%b expected 0 00 0 0",
               mem_stb_o, grant_o, data_ack_o, instr_ack_o);
    end
    sys_rst = 0;
    tick();
    n_cmp++;
    if ({grant_o, mem_addr_o, data_ack_o} !== {2'b01, 16'h0400, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_regrant: got grant=%b addr=%h dack=%b expected 01 0400 0",
               grant_o, mem_addr_o, data_ack_o);
    end
    mem_ack_i = 1; mem_data_i = 16'hCAFE;
    tick();
    n_cmp++;
    if ({instr_ack_o, instr_data_o, data_ack_o} !== {1'b1, 16'hCAFE, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_ack: got iack=%b id=%h dack=%b expected 1 cafe 0",
               instr_ack_o, instr_data_o, data_ack_o);
    end
    instr_stb_i = 0; data_stb_i = 0; mem_ack_i = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_wait();
    test_contention();
    test_timeout();
    test_ack_expiry();
    test_reset_mid_bus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one 16-bit single-port memory between the CPU instruction-fetch port and the CPU data port. Each requester uses the stb/we/ack handshake the CPU core already drives; the arbiter latches one request at a time and replays it on the memory port. Round-robin on contention, with a timeout that terminates a memory access the memory never acknowledges. The arbiter sits between the CPU core and the unified memory.

## Interface
- TIMEOUT, 15: max cycles in BUS waiting for mem_ack_i before abort (1..2^TO_W-1)
- TO_W, 4: timeout counter width
- sys_clk  in  1  clock, all logic rising-edge
- sys_rst  in  1  synchronous, active-high reset
- instr_stb_i  in  1  instruction-side request strobe, held until instr_ack_o
- instr_we_i  in  1  instruction-side write enable (normally 0)
- instr_addr_i  in  16  instruction-side address
- instr_data_i  in  16  instruction-side write data
- instr_data_o  out  16  read data to instruction side
- instr_ack_o  out  1  one-cycle completion pulse
- instr_err_o  out  1  one-cycle timeout flag, coincident with instr_ack_o
- data_stb_i, data_we_i, data_addr_i[16], data_data_i[16]  in  request signals, data side (same semantics)
- data_data_o  out  16, data_ack_o  out  1, data_err_o  out  1  response signals, data side
- mem_stb_o  out  1  memory request strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  16  memory address
- mem_data_o  out  16  memory write data
- mem_data_i  in  16  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion
- grant_o  out  2  current owner: 00 none, 01 instr, 10 data

## Operation
- States: IDLE, BUS, RESP. Register last_grant (0 instr, 1 data).
- IDLE: sample stbs. Only one high -> grant it. Both high -> grant the side not equal to last_grant. On grant: latch we/addr/wdata of winner into mem_*_o regs, set grant_o, clear timeout counter, -> BUS, last_grant <= winner. Neither -> stay.
- BUS: mem_stb_o=1, mem_we_o/addr/data stable from latches. Counter increments each BUS cycle.
  - mem_ack_i=1: capture mem_data_i (reads; writes capture too, value don't-care) into owner's data_o reg, -> RESP, err=0.
  - no ack and counter == TIMEOUT-1: -> RESP with err=1, owner data_o <= 16'hFFFF.
  - ack on the expiry cycle: ack wins, err=0.
- RESP: owner's ack_o=1 (and err_o if timeout) for exactly this cycle; mem_stb_o=0; requester stbs ignored this cycle (owner still holds stb). -> IDLE, grant_o <= 00.
- Non-owner's request waits untouched; its ack_o/err_o stay 0; its data_o holds last value.
- Requester dropping stb during BUS or RESP: transaction still completes; ack still pulses.
- Requester inputs are not re-sampled after grant; changes during BUS do not reach memory.

## Timing
- Reset (sys_rst=1 at edge): state IDLE, last_grant=1 (instr wins first tie), grant_o=00, mem_stb_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, instr/data_ack_o=0, instr/data_err_o=0, instr/data_data_o=0, counter=0. Reset mid-BUS drops mem_stb_o on the next edge; no ack issued for the aborted transaction.
- Cycle n: stb seen in IDLE. n+1: mem_stb_o=1. Memory acks at n+1+k (k>=0). n+2+k: requester ack_o=1. n+3+k: IDLE, earliest new grant sample.
- Minimum turnaround: 3 cycles per transaction (zero-wait memory); back-to-back from both sides alternate.
- Timeout: stb at n, mem_stb_o high n+1..n+TIMEOUT, ack_o+err_o at n+TIMEOUT+1.
- All outputs registered; no combinational path from any input to any output.
- mem_ack_i outside BUS ignored.

## Test plan
- Single read: data_stb_i=1, we=0, addr=16'h0040; memory acks zero-wait with 16'hBEEF -> mem_stb_o high 1 cycle, mem_addr_o=0040, data_ack_o pulses 2 cycles after stb sample, data_data_o=BEEF, grant_o 10 then 00.
- Write with 3 wait states: instr_stb_i=1, we=1, addr=0x0010, wdata=0x1234 -> mem_stb_o high 4 cycles with mem_we_o=1, mem_data_o=1234; instr_ack_o one pulse; data side untouched.
- Contention after reset: both stbs high continuously, zero-wait memory -> grants instr, data, instr, data; each ack 3 cycles apart; no side starved.
- Timeout: data read, memory never acks, TIMEOUT=15 -> mem_stb_o high exactly 15 cycles, then data_ack_o=1, data_err_o=1, data_data_o=FFFF; next request served normally.
- Ack on expiry cycle: mem_ack_i at 15th BUS cycle with 0x5A5A -> err_o=0, data_o=5A5A.
- Reset mid-BUS: assert sys_rst during wait state -> next edge mem_stb_o=0, grant_o=00, no ack; after release, pending instr request granted first.
